// File: rtl/fp_mul_frac_seq.sv
// Multi-cycle fraction multiplier: unpacks two IEEE-style operands, multiplies the
// hidden-bit mantissas RADIX_BITS per cycle, normalises. FPU_MUL_STICKY_EN adds a sticky output.
module fp_mul_frac_seq #(
    parameter int EXP_W      = 8,
    parameter int FRAC_W     = 23,
    parameter int GUARD_W    = 2,
    parameter int RADIX_BITS = 2,
    localparam int W     = 1 + EXP_W + FRAC_W,
    localparam int M     = 1 + FRAC_W + GUARD_W,
    localparam int ITER  = (M + RADIX_BITS - 1) / RADIX_BITS,
    localparam int MP    = ITER * RADIX_BITS,
    localparam int CNT_W = $clog2(ITER + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     fp1_in,
    input  logic [W-1:0]     fp2_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign1,
    output logic             sign2,
    output logic [EXP_W-1:0] exp1,
    output logic [EXP_W-1:0] exp2,
    output logic [M-1:0]     product,
    output logic             carry_out
`ifdef FPU_MUL_STICKY_EN
    ,
    output logic             sticky
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*M-1:0]     mcand_q, mcand_d;
    logic [MP-1:0]      mplr_q, mplr_d;
    logic [2*M-1:0]     acc_q, acc_d;
    logic               sign1_q, sign1_d, sign2_q, sign2_d;
    logic [EXP_W-1:0]   exp1_q, exp1_d, exp2_q, exp2_d;
    logic [M-1:0]       prod_q, prod_d;
    logic               carry_q, carry_d;

    logic [M-1:0]       mant1, mant2;
    logic [2*M-1:0]     pp;
    logic               carry_n;
    logic [M-1:0]       prod_n;

    // Hidden bit is 0 for zero/denormal exponents; guard bits are zero padding.
    assign mant1 = {|fp1_in[W-2:FRAC_W], fp1_in[FRAC_W-1:0], {GUARD_W{1'b0}}};
    assign mant2 = {|fp2_in[W-2:FRAC_W], fp2_in[FRAC_W-1:0], {GUARD_W{1'b0}}};

    // Multiplicand is pre-shifted each cycle, so the digit partial product lands at its weight.
    assign pp      = mcand_q * (2*M)'(mplr_q[RADIX_BITS-1:0]);
    assign carry_n = acc_q[2*M-1];
    assign prod_n  = carry_n ? acc_q[2*M-1:M] : acc_q[2*M-2:M-1];

`ifdef FPU_MUL_STICKY_EN
    logic sticky_q, sticky_d, sticky_n;
    assign sticky_n = carry_n ? |acc_q[M-1:0] : |acc_q[M-2:0];
    assign sticky   = sticky_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
        exp1_d  = exp1_q;
        exp2_d  = exp2_q;
        prod_d  = prod_q;
        carry_d = carry_q;
`ifdef FPU_MUL_STICKY_EN
        sticky_d = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign1_d = fp1_in[W-1];
                    sign2_d = fp2_in[W-1];
                    exp1_d  = fp1_in[W-2:FRAC_W];
                    exp2_d  = fp2_in[W-2:FRAC_W];
                    mcand_d = (2*M)'(mant1);
                    mplr_d  = MP'(mant2);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // One extra cycle after the last add registers the normalised result.
                if (cnt_q == CNT_W'(ITER)) begin
                    prod_d  = prod_n;
                    carry_d = carry_n;
`ifdef FPU_MUL_STICKY_EN
                    sticky_d = sticky_n;
`endif
                    state_d = DONE;
                end else begin
                    acc_d   = acc_q + pp;
                    mcand_d = mcand_q << RADIX_BITS;
                    mplr_d  = mplr_q >> RADIX_BITS;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            exp1_q  <= '0;
            exp2_q  <= '0;
            prod_q  <= '0;
            carry_q <= 1'b0;
`ifdef FPU_MUL_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            exp1_q  <= exp1_d;
            exp2_q  <= exp2_d;
            prod_q  <= prod_d;
            carry_q <= carry_d;
`ifdef FPU_MUL_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sign1     = sign1_q;
    assign sign2     = sign2_q;
    assign exp1      = exp1_q;
    assign exp2      = exp2_q;
    assign product   = prod_q;
    assign carry_out = carry_q;

endmodule
